// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: phase encodings, config bundle and 640x480@60 defaults.
// Optional line prefetch is built when VGA_LINE_PREFETCH_EN is defined.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'b00,
    BP   = 2'b01,
    DISP = 2'b10,
    FP   = 2'b11
  } phase_t;

  typedef struct packed {
    logic hpol;
    logic vpol;
    logic blank;
  } vga_cfg_t;

  localparam vga_cfg_t CFG_DEFAULT = '{hpol: 1'b0, vpol: 1'b0, blank: 1'b0};

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_SHOLD   = 96;
  localparam int DEF_H_SBP     = 48;
  localparam int DEF_H_SFP     = 16;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_SHOLD   = 2;
  localparam int DEF_V_SBP     = 33;
  localparam int DEF_V_SFP     = 10;
  localparam int DEF_CNT_BITS  = 10;
  localparam int DEF_PF_LEAD   = 8;

endpackage

// File: rtl/vga_timing_sequencer_phase_counter.sv
// vga_phase_counter: one axis of SYNC->BP->DISP->FP phase sequencing.
// Exposes the post-advance state so the top can register outputs on the same edge.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_bp,
  input  logic [CW-1:0] len_disp,
  input  logic [CW-1:0] len_fp,
  output phase_t        phase,
  output logic [CW-1:0] cnt,
  output logic          last,
  output phase_t        nxt_phase,
  output logic [CW-1:0] nxt_cnt
);

  logic [CW-1:0] len_cur;
  logic          at_end;

  // length of the phase being counted
  always_comb begin
    len_cur = len_fp;
    unique case (phase)
      SYNC: len_cur = len_sync;
      BP:   len_cur = len_bp;
      DISP: len_cur = len_disp;
      FP:   len_cur = len_fp;
    endcase
  end

  assign at_end = (cnt == len_cur - 1'b1);
  assign last   = (phase == FP) && (cnt == len_fp - 1'b1);

  // next phase/count when advanced
  always_comb begin
    nxt_phase = phase;
    nxt_cnt   = cnt;
    if (advance) begin
      if (at_end) begin
        nxt_phase = phase_t'(phase + 2'd1);
        nxt_cnt   = '0;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end
  end

  // state register; reset parks on the last FP count
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= FP;
      cnt   <= len_fp - 1'b1;
    end else begin
      phase <= nxt_phase;
      cnt   <= nxt_cnt;
    end
  end

endmodule

// File: rtl/vga_timing_sequencer.sv
// vga_timing_sequencer: pixel divider, H/V sequencing, sync and config.
// Define VGA_LINE_PREFETCH_EN to build the per-line prefetch pulse.
module vga_timing_sequencer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int H_DISPLAY     = DEF_H_DISPLAY,
  parameter int H_SHOLD       = DEF_H_SHOLD,
  parameter int H_SBP         = DEF_H_SBP,
  parameter int H_SFP         = DEF_H_SFP,
  parameter int V_DISPLAY     = DEF_V_DISPLAY,
  parameter int V_SHOLD       = DEF_V_SHOLD,
  parameter int V_SBP         = DEF_V_SBP,
  parameter int V_SFP         = DEF_V_SFP,
  parameter int COUNTER_BITS  = DEF_CNT_BITS,
  parameter int PREFETCH_LEAD = DEF_PF_LEAD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_hpol,
  input  logic                    cfg_vpol,
  input  logic                    cfg_blank,
  output logic                    VGA_HSYNC,
  output logic                    VGA_VSYNC,
  output logic                    displaying,
  output logic [COUNTER_BITS-1:0] pixel_x,
  output logic [COUNTER_BITS-1:0] pixel_y,
  output logic                    pixel_tick,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    prefetch_req
);

  localparam int CW = COUNTER_BITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] HL_S = CW'(H_SHOLD);
  localparam logic [CW-1:0] HL_B = CW'(H_SBP);
  localparam logic [CW-1:0] HL_D = CW'(H_DISPLAY);
  localparam logic [CW-1:0] HL_F = CW'(H_SFP);
  localparam logic [CW-1:0] VL_S = CW'(V_SHOLD);
  localparam logic [CW-1:0] VL_B = CW'(V_SBP);
  localparam logic [CW-1:0] VL_D = CW'(V_DISPLAY);
  localparam logic [CW-1:0] VL_F = CW'(V_SFP);

  logic [DW-1:0] div;
  logic          tick;
  logic          line_end;
  logic          frame_end;

  phase_t        h_phase, h_nxt;
  phase_t        v_phase, v_nxt;
  logic [CW-1:0] h_cnt, h_nxt_cnt;
  logic [CW-1:0] v_cnt, v_nxt_cnt;
  logic          h_last, v_last;

  vga_cfg_t      act_cfg, pend_cfg, nxt_cfg;
  logic          pend_full;
  logic          apply;

  // pixel-clock divider, frozen while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  assign tick      = enable && (div == DIV_LAST);
  assign line_end  = tick && h_last;
  assign frame_end = line_end && v_last;

  vga_phase_counter #(.CW(CW)) u_h (
    .clk       (clk),
    .reset     (reset),
    .advance   (tick),
    .len_sync  (HL_S),
    .len_bp    (HL_B),
    .len_disp  (HL_D),
    .len_fp    (HL_F),
    .phase     (h_phase),
    .cnt       (h_cnt),
    .last      (h_last),
    .nxt_phase (h_nxt),
    .nxt_cnt   (h_nxt_cnt)
  );

  vga_phase_counter #(.CW(CW)) u_v (
    .clk       (clk),
    .reset     (reset),
    .advance   (line_end),
    .len_sync  (VL_S),
    .len_bp    (VL_B),
    .len_disp  (VL_D),
    .len_fp    (VL_F),
    .phase     (v_phase),
    .cnt       (v_cnt),
    .last      (v_last),
    .nxt_phase (v_nxt),
    .nxt_cnt   (v_nxt_cnt)
  );

  assign apply   = frame_end && pend_full;
  assign nxt_cfg = apply ? pend_cfg : act_cfg;

  // config slot: accept into pending, promote on frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      act_cfg   <= CFG_DEFAULT;
      pend_cfg  <= CFG_DEFAULT;
      pend_full <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      if (apply) begin
        act_cfg   <= pend_cfg;
        pend_full <= 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
        pend_cfg  <= '{hpol: cfg_hpol, vpol: cfg_vpol, blank: cfg_blank};
        pend_full <= 1'b1;
        cfg_ready <= 1'b0;
      end else if (!cfg_ready && !pend_full) begin
        cfg_ready <= 1'b1;
      end
    end
  end

  // registered outputs, refreshed on each pixel tick
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_HSYNC   <= !CFG_DEFAULT.hpol;
      VGA_VSYNC   <= !CFG_DEFAULT.vpol;
      displaying  <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= tick;
      line_start  <= line_end;
      frame_start <= frame_end;
      if (tick) begin
        VGA_HSYNC  <= (h_nxt == SYNC) ? nxt_cfg.hpol : !nxt_cfg.hpol;
        VGA_VSYNC  <= (v_nxt == SYNC) ? nxt_cfg.vpol : !nxt_cfg.vpol;
        displaying <= (h_nxt == DISP) && (v_nxt == DISP)
                      && !nxt_cfg.blank;
        pixel_x    <= (h_nxt == DISP) ? h_nxt_cnt : '0;
        pixel_y    <= (v_nxt == DISP) ? v_nxt_cnt : '0;
      end
    end
  end

`ifdef VGA_LINE_PREFETCH_EN
  localparam logic [CW-1:0] PF_CNT = CW'(H_SBP - PREFETCH_LEAD);

  // one pulse per visible line, PREFETCH_LEAD pixels ahead of DISP
  always_ff @(posedge clk) begin
    if (reset) begin
      prefetch_req <= 1'b0;
    end else begin
      prefetch_req <= tick && (h_nxt == BP) && (h_nxt_cnt == PF_CNT)
                      && (v_phase == DISP) && !nxt_cfg.blank;
    end
  end
`else
  assign prefetch_req = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// tb_vga_timing_sequencer: directed vectors on a shrunken raster.
// Position-based reference derives expected outputs from the tick count.
module tb_vga_timing_sequencer;

  localparam int DIV = 2;
  localparam int HS = 3, HB = 4, HD = 8, HF = 2;
  localparam int VS = 1, VB = 2, VD = 4, VF = 1;
  localparam int CW = 10, PL = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int FCLK = FT * DIV;
`ifdef VGA_LINE_PREFETCH_EN
  localparam int EXP_PF = VD;
`else
  localparam int EXP_PF = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_hpol = 1'b0, cfg_vpol = 1'b0, cfg_blank = 1'b0;
  logic cfg_ready;
  logic VGA_HSYNC, VGA_VSYNC, displaying;
  logic [CW-1:0] pixel_x, pixel_y;
  logic pixel_tick, line_start, frame_start, prefetch_req;

  always #5 clk = ~clk;

  vga_timing_sequencer #(
    .CLK_DIV(DIV), .H_DISPLAY(HD), .H_SHOLD(HS), .H_SBP(HB),
    .H_SFP(HF), .V_DISPLAY(VD), .V_SHOLD(VS), .V_SBP(VB),
    .V_SFP(VF), .COUNTER_BITS(CW), .PREFETCH_LEAD(PL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_blank(cfg_blank),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
    .displaying(displaying), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_tick(pixel_tick), .line_start(line_start),
    .frame_start(frame_start), .prefetch_req(prefetch_req)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference state
  int ecnt = 0, t = 0;
  logic m_ready = 1'b0, m_pf = 1'b0, m_acc = 1'b0;
  logic [2:0] m_pend = 3'b000, m_act = 3'b000;
  logic e_hs = 1'b1, e_vs = 1'b1, e_disp = 1'b0;
  logic e_pt = 1'b0, e_ls = 1'b0, e_fs = 1'b0, e_pf = 1'b0;
  int e_x = 0, e_y = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic en_s, rst_s, val_s, tk, hd, vd, old_pf;
    logic [2:0] in_s;
    int p, hx, ln;
    en_s  = enable;
    rst_s = reset;
    val_s = cfg_valid;
    in_s  = {cfg_hpol, cfg_vpol, cfg_blank};
    @(posedge clk);
    #1;
    m_acc = 1'b0;
    if (rst_s) begin
      ecnt = 0; t = 0;
      m_ready = 1'b0; m_pf = 1'b0; m_act = 3'b000; m_pend = 3'b000;
      e_hs = 1'b1; e_vs = 1'b1; e_disp = 1'b0; e_x = 0; e_y = 0;
      e_pt = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_pf = 1'b0;
    end else begin
      tk = 1'b0;
      if (en_s) begin
        ecnt++;
        tk = (ecnt % DIV == 0);
      end
      e_pt = tk; e_ls = 1'b0; e_fs = 1'b0; e_pf = 1'b0;
      old_pf = m_pf;
      if (tk) begin
        t++;
        p  = (t - 1) % FT;
        hx = p % HT;
        ln = p / HT;
        if (p == 0 && old_pf) begin
          m_act = m_pend;
          m_pf  = 1'b0;
        end
        hd = (hx >= HS + HB) && (hx < HS + HB + HD);
        vd = (ln >= VS + VB) && (ln < VS + VB + VD);
        e_hs   = (hx < HS) ? m_act[2] : !m_act[2];
        e_vs   = (ln < VS) ? m_act[1] : !m_act[1];
        e_disp = hd && vd && !m_act[0];
        e_x    = hd ? hx - HS - HB : 0;
        e_y    = vd ? ln - VS - VB : 0;
        e_ls   = (hx == 0);
        e_fs   = (p == 0);
`ifdef VGA_LINE_PREFETCH_EN
        e_pf   = (hx == HS + HB - PL) && vd && !m_act[0];
`endif
      end
      if (m_ready && val_s) begin
        m_pend = in_s; m_pf = 1'b1; m_ready = 1'b0; m_acc = 1'b1;
      end else if (!m_ready && !old_pf) begin
        m_ready = 1'b1;
      end
    end
    chk("hsync", VGA_HSYNC, e_hs);
    chk("vsync", VGA_VSYNC, e_vs);
    chk("displaying", displaying, e_disp);
    chk("pixel_x", pixel_x, e_x);
    chk("pixel_y", pixel_y, e_y);
    chk("pixel_tick", pixel_tick, e_pt);
    chk("line_start", line_start, e_ls);
    chk("frame_start", frame_start, e_fs);
    chk("prefetch", prefetch_req, e_pf);
    chk("cfg_ready", cfg_ready, m_ready);
  endtask

  task automatic run_frame(input string tag, input int x_disp,
                           input int x_pf, input int x_hlow,
                           input int x_vlow);
    int nd, np, nl, nf, hl, vl;
    nd = 0; np = 0; nl = 0; nf = 0; hl = 0; vl = 0;
    for (int i = 0; i < FCLK; i++) begin
      step();
      if (pixel_tick && displaying) nd++;
      if (prefetch_req) np++;
      if (line_start) nl++;
      if (frame_start) nf++;
      if (!VGA_HSYNC) hl++;
      if (!VGA_VSYNC) vl++;
    end
    chk({tag, "_disp"}, nd, x_disp);
    chk({tag, "_pf"}, np, x_pf);
    chk({tag, "_lines"}, nl, VT);
    chk({tag, "_frames"}, nf, 1);
    chk({tag, "_hlow"}, hl, x_hlow);
    chk({tag, "_vlow"}, vl, x_vlow);
  endtask

  task automatic wait_fs(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FCLK && !seen; i++) begin
      step();
      seen = frame_start;
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic offer(input string tag, input logic h, input logic v,
                       input logic b);
    logic done;
    done = 1'b0;
    cfg_hpol = h; cfg_vpol = v; cfg_blank = b;
    cfg_valid = 1'b1;
    for (int i = 0; i < 2 * FCLK && !done; i++) begin
      step();
      done = m_acc;
    end
    cfg_valid = 1'b0;
    chk({tag, "_acc"}, done, 1'b1);
    chk({tag, "_rdy_drop"}, cfg_ready, 1'b0);
  endtask

  initial begin
    int nstr;
    logic hit;

    // reset values
    reset = 1'b1; enable = 1'b0;
    repeat (3) step();
    reset = 1'b0; enable = 1'b1;
    step();
    chk("fs_clk1", frame_start, 1'b0);
    chk("rdy_after_rst", cfg_ready, 1'b1);
    step();
    chk("fs_clk2", frame_start, 1'b1);
    chk("ls_clk2", line_start, 1'b1);
    chk("hs_clk2", VGA_HSYNC, 1'b0);
    run_frame("f0", HD * VD, EXP_PF, HS * DIV * VT, VS * HT * DIV);

    // hpol=1 offered mid-frame, flips at the next frame start
    repeat (50) step();
    offer("hpol", 1'b1, 1'b0, 1'b0);
    chk("hs_before", VGA_HSYNC, 1'b1);
    wait_fs("hpol_fs");
    chk("hs_flip", VGA_HSYNC, 1'b1);
    chk("rdy_wait", cfg_ready, 1'b0);
    step();
    chk("rdy_back", cfg_ready, 1'b1);
    run_frame("hpol", HD * VD, EXP_PF, (HT - HS) * DIV * VT,
              VS * HT * DIV);

    // accept on the frame_start edge itself with blank=1
    hit = 1'b0;
    for (int i = 0; i < 2 * FCLK && !hit; i++) begin
      if (((ecnt + 1) % DIV == 0) && (t > 0) && (t % FT == 0)) hit = 1'b1;
      else step();
    end
    chk("fs_align", hit, 1'b1);
    cfg_hpol = 1'b1; cfg_vpol = 1'b0; cfg_blank = 1'b1;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("same_fs", frame_start, 1'b1);
    chk("same_acc", cfg_ready, 1'b0);
    run_frame("cur", HD * VD, EXP_PF, (HT - HS) * DIV * VT, VS * HT * DIV);
    run_frame("blank", 0, 0, (HT - HS) * DIV * VT, VS * HT * DIV);

    offer("unblank", 1'b1, 1'b0, 1'b0);
    wait_fs("unblank_fs");
    run_frame("unblank", HD * VD, EXP_PF, (HT - HS) * DIV * VT,
              VS * HT * DIV);

    // freeze for 37 clk mid-line
    repeat (41) step();
    enable = 1'b0;
    nstr = 0;
    repeat (37) begin
      step();
      if (pixel_tick || line_start || frame_start || prefetch_req) nstr++;
    end
    chk("frz_strobes", nstr, 0);
    enable = 1'b1;
    repeat (60) step();

    // reset mid-frame discards a pending config
    offer("pend", 1'b0, 1'b1, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    chk("rst_hs", VGA_HSYNC, 1'b1);
    chk("rst_rdy", cfg_ready, 1'b0);
    reset = 1'b0;
    step();
    chk("rst_fs1", frame_start, 1'b0);
    step();
    chk("rst_fs2", frame_start, 1'b1);
    run_frame("post_rst", HD * VD, EXP_PF, HS * DIV * VT, VS * HT * DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_sequencer.md
Name: vga_timing_sequencer

Overview:
- Top-level VGA timing controller; sequences one horizontal and one vertical 4-phase sync sequence from the system clock.
- Divides the system clock down to a pixel tick and provides pixel coordinates, frame/line strobes and sync outputs to the pixel pipeline.
- Accepts polarity/blank configuration over a valid/ready handshake; new configuration takes effect only on a frame boundary.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); >=1
- H_DISPLAY, 640, H visible pixels
- H_SHOLD, 96, H sync pulse pixels
- H_SBP, 48, H back porch pixels
- H_SFP, 16, H front porch pixels
- V_DISPLAY, 480, V visible lines
- V_SHOLD, 2, V sync pulse lines
- V_SBP, 33, V back porch lines
- V_SFP, 10, V front porch lines
- COUNTER_BITS, 10, width of the phase counters and coordinates; must hold every length minus 1
- PREFETCH_LEAD, 8, pixels before H DISP at which prefetch fires; 1..H_SBP

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  0 freezes the divider and all counters; outputs hold
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  config slot free
- cfg_hpol  in  1  1 = HSYNC active-high
- cfg_vpol  in  1  1 = VSYNC active-high
- cfg_blank  in  1  1 = force displaying low
- VGA_HSYNC  out  1  horizontal sync
- VGA_VSYNC  out  1  vertical sync
- displaying  out  1  current pixel visible
- pixel_x  out  COUNTER_BITS  column in H DISP, 0 elsewhere
- pixel_y  out  COUNTER_BITS  line in V DISP, 0 elsewhere
- pixel_tick  out  1  one-clk pulse, first cycle of each pixel
- line_start  out  1  one-clk pulse, entry to H SYNC
- frame_start  out  1  one-clk pulse, entry to V SYNC (coincides with line_start)
- prefetch_req  out  1  line prefetch pulse (optional feature)

Behaviour:
- Divider: div counts 0..CLK_DIV-1 while enable=1. Internal tick = enable && div==CLK_DIV-1. With CLK_DIV=1, tick = enable.
- Phase sequence per axis: SYNC -> BP -> DISP -> FP -> SYNC. cnt counts 0..len-1 within a phase. At cnt==len-1 the phase advances and cnt clears.
- H axis advances on tick. V axis advances on tick when H is in FP with cnt==H_SFP-1 (line end).
- All outputs are registered and update on the tick edge; pixel_tick is set on that same edge, so it is high for the first clk of each new pixel.
- Reset state: H=FP cnt H_SFP-1, V=FP cnt V_SFP-1. The first tick after reset therefore enters SYNC/SYNC and raises line_start and frame_start.
- Reset output values: sync pins at the deasserted level of the default polarity (active-low, so 1); displaying, pixel_x, pixel_y, pixel_tick, line_start, frame_start, prefetch_req = 0; cfg_ready = 0 during reset and 1 on the first cycle after.
- Sync pins: asserted level = active polarity while the axis is in SYNC, else the inverse.
- displaying = H DISP && V DISP && !active_blank.
- pixel_x = H cnt in DISP. pixel_y = V cnt in V DISP, held for the whole line.
- Active config defaults: hpol=0, vpol=0, blank=0.
- Config handshake: accept on the edge where cfg_valid && cfg_ready; store in the pending register and drop cfg_ready. Pending is copied to active on the frame_start edge; cfg_ready rises on the next cycle.
- Accept on the same edge as frame_start: applied at the following frame_start, not this one.
- cfg_valid while cfg_ready=0: ignored; the requester holds it.
- enable=0 mid-pixel: div holds; no strobes fire; strobes are never stretched.
- Reset mid-frame: immediate return to the reset state on the next edge; pending config is discarded.
- Frame totals: 800 clk-ticks x 525 lines at defaults.

Optional Feature:
- Macro VGA_LINE_PREFETCH_EN.
- Defined: prefetch_req pulses for one clk on the tick edge entering H BP cnt==H_SBP-PREFETCH_LEAD, only when V is in DISP and active_blank=0. Fires once per visible line.
- Undefined: prefetch_req tied 0 and no comparator logic is built.

Decomposition:
- Package vga_timing_pkg: phase encodings SYNC=2'b00, BP=2'b01, DISP=2'b10, FP=2'b11; 640x480@60 default constants.
- Sub-module vga_phase_counter, instantiated twice (H, V).
  - Inputs: clk, reset, advance, four length values.
  - Outputs: phase, cnt, last (phase==FP && cnt==len_fp-1).

Test Plan:
- Reset, then enable=1 at defaults -> frame_start+line_start on the 4th clk; HSYNC low for 96 ticks (384 clk); line period 3200 clk; frame period 1,680,000 clk.
- Visible region -> displaying high for exactly 640 ticks per line on 480 lines; pixel_x 0..639 and pixel_y 0..479; first visible pixel at tick 144 of line 35.
- cfg_valid with hpol=1 mid-frame -> cfg_ready drops the next cycle; HSYNC polarity flips only at the next frame_start; cfg_ready returns 1 cycle later.
- cfg handshake on the same edge as frame_start, blank=1 -> current frame unblanked; displaying stays 0 for all of the following frame.
- enable=0 for 37 clk mid-line, reset asserted mid-frame -> counters/outputs frozen without extra strobes; after reset, output state matches the post-reset sequence exactly.
- VGA_LINE_PREFETCH_EN defined, PREFETCH_LEAD=8 -> 480 prefetch pulses per frame, each 8 ticks (32 clk) before displaying rises; none when blank=1.
